// File: rtl/vlc_input_conditioner.sv
// vlc_input_conditioner
// Conditions the raw turn-left, turn-right and emergency lamp switches before
// the vehicle lamp controller: two-flop synchronisation, per-channel debounce,
// and a four-state arbiter that lets at most one command through.
//
// Build option: define VLC_COND_LATCH_EN to make the emergency switch act as a
// push-button.
// - Each accepted press toggles the hazard latch.
// - Without the macro, hazard follows the debounced switch level.
// - Without the macro, no latch flop exists.
//
// Channel index used throughout: 0 = left, 1 = right, 2 = emergency.

module vlc_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_left,
    input  logic raw_right,
    input  logic raw_emerg,
    output logic Turn_Left,
    output logic Turn_Right,
    output logic Emergency,
    output logic cmd_change,
    output logic conflict
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LEFT   = 2'b01,
        ST_RIGHT  = 2'b10,
        ST_HAZARD = 2'b11
    } state_t;

    logic [2:0]            raw_s;
    logic [2:0]            meta_r;
    logic [2:0]            sync_r;
    logic [2:0]            deb_r;
    logic [2:0]            deb_nxt_s;
    logic [2:0][CNT_W-1:0] cnt_r;
    logic [2:0][CNT_W-1:0] cnt_nxt_s;
    logic                  hz_s;
    state_t                state_r;
    state_t                next_state_s;
    logic                  turn_left_nxt_s;
    logic                  turn_right_nxt_s;
    logic                  emergency_nxt_s;
    logic                  turn_left_r;
    logic                  turn_right_r;
    logic                  emergency_r;
    logic                  cmd_change_r;
    logic                  conflict_r;

    assign raw_s = {raw_emerg, raw_right, raw_left};

    // Two-flop synchroniser for every switch input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r <= 3'b000;
            sync_r <= 3'b000;
        end else begin
            meta_r <= raw_s;
            sync_r <= meta_r;
        end
    end

    // Debounce next-value: count consecutive mismatches, accept on the last one
    always_comb begin
        deb_nxt_s = deb_r;
        cnt_nxt_s = cnt_r;
        for (int i = 0; i < 3; i++) begin
            if (sync_r[i] != deb_r[i]) begin
                if (cnt_r[i] == CNT_LAST) begin
                    deb_nxt_s[i] = sync_r[i];
                    cnt_nxt_s[i] = CNT_ZERO;
                end else begin
                    deb_nxt_s[i] = deb_r[i];
                    cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
                end
            end else begin
                deb_nxt_s[i] = deb_r[i];
                cnt_nxt_s[i] = CNT_ZERO;
            end
        end
    end

    // Debounced values and their stability counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_r <= 3'b000;
            cnt_r <= {3{CNT_ZERO}};
        end else begin
            deb_r <= deb_nxt_s;
            cnt_r <= cnt_nxt_s;
        end
    end

`ifdef VLC_COND_LATCH_EN
    logic latch_q_r;
    logic latch_nxt_s;

    // Toggle the hazard latch on the cycle the debounced button is accepted high
    always_comb begin
        latch_nxt_s = latch_q_r ^ (deb_nxt_s[2] & ~deb_r[2]);
    end

    // Hazard latch register, aligned with the debounced values
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            latch_q_r <= 1'b0;
        end else begin
            latch_q_r <= latch_nxt_s;
        end
    end

    assign hz_s = latch_q_r;
`else
    assign hz_s = deb_r[2];
`endif

    // Arbiter next state: hazard overrides everything, and the first turn to arrive wins
    always_comb begin
        next_state_s = state_r;
        if (hz_s) begin
            next_state_s = ST_HAZARD;
        end else begin
            case (state_r)
                ST_HAZARD: begin
                    // Turns are re-arbitrated from IDLE on the following clock
                    next_state_s = ST_IDLE;
                end
                ST_IDLE: begin
                    if (deb_r[0] && !deb_r[1]) begin
                        next_state_s = ST_LEFT;
                    end else if (deb_r[1] && !deb_r[0]) begin
                        next_state_s = ST_RIGHT;
                    end else begin
                        next_state_s = ST_IDLE;
                    end
                end
                ST_LEFT: begin
                    if (!deb_r[0]) begin
                        next_state_s = ST_IDLE;
                    end else begin
                        next_state_s = ST_LEFT;
                    end
                end
                ST_RIGHT: begin
                    if (!deb_r[1]) begin
                        next_state_s = ST_IDLE;
                    end else begin
                        next_state_s = ST_RIGHT;
                    end
                end
                default: begin
                    next_state_s = ST_IDLE;
                end
            endcase
        end
    end

    // Decode the upcoming state so the command registers switch with the state register
    always_comb begin
        turn_left_nxt_s  = 1'b0;
        turn_right_nxt_s = 1'b0;
        emergency_nxt_s  = 1'b0;
        case (next_state_s)
            ST_LEFT:   turn_left_nxt_s  = 1'b1;
            ST_RIGHT:  turn_right_nxt_s = 1'b1;
            ST_HAZARD: emergency_nxt_s  = 1'b1;
            ST_IDLE:   turn_left_nxt_s  = 1'b0;
            default:   turn_left_nxt_s  = 1'b0;
        endcase
    end

    // Arbiter state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Registered commands, change pulse and turn-conflict flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            turn_left_r  <= 1'b0;
            turn_right_r <= 1'b0;
            emergency_r  <= 1'b0;
            cmd_change_r <= 1'b0;
            conflict_r   <= 1'b0;
        end else begin
            turn_left_r  <= turn_left_nxt_s;
            turn_right_r <= turn_right_nxt_s;
            emergency_r  <= emergency_nxt_s;
            cmd_change_r <= (next_state_s != state_r);
            conflict_r   <= deb_nxt_s[0] & deb_nxt_s[1];
        end
    end

    assign Turn_Left  = turn_left_r;
    assign Turn_Right = turn_right_r;
    assign Emergency  = emergency_r;
    assign cmd_change = cmd_change_r;
    assign conflict   = conflict_r;

endmodule

// File: tb/tb_vlc_input_conditioner.sv
// Self-checking bench for vlc_input_conditioner with DEBOUNCE_CYCLES = 4, so the
// pin-to-command latency is 7 clocks.
//
// Each task pushes the expected output vector for every upcoming cycle into a
// queue, drives the switches, then pops and compares one entry per clock.
//
// The vector layout is {conflict, cmd_change, Emergency, Turn_Right, Turn_Left}.
// Cycle k means the state just after the k-th rising edge following the
// stimulus change.

module tb_vlc_input_conditioner;

    logic clk = 1'b0;
    logic rst;
    logic raw_left;
    logic raw_right;
    logic raw_emerg;
    logic Turn_Left;
    logic Turn_Right;
    logic Emergency;
    logic cmd_change;
    logic conflict;

    logic [4:0] obs;
    logic [4:0] exp_q[$];
    logic [4:0] exp_v;
    int checks = 0;
    int errors = 0;

    assign obs = {conflict, cmd_change, Emergency, Turn_Right, Turn_Left};

    vlc_input_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .raw_left  (raw_left),
        .raw_right (raw_right),
        .raw_emerg (raw_emerg),
        .Turn_Left (Turn_Left),
        .Turn_Right(Turn_Right),
        .Emergency (Emergency),
        .cmd_change(cmd_change),
        .conflict  (conflict)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] pack(bit tl, bit tr, bit em, bit cc, bit cf);
        return {cf, cc, em, tr, tl};
    endfunction

    task automatic test_reset;
        for (int k = 1; k <= 6; k++) exp_q.push_back(5'b00000);
        for (int k = 1; k <= 6; k++) begin
            tick;
            if (k == 3) rst = 1'b0;
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL reset cyc=%0d got=%b want=%b", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_single_left;
        for (int k = 1; k <= 10; k++) exp_q.push_back(pack(k >= 7, 1'b0, 1'b0, k == 7, 1'b0));
        raw_left = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick;
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL single_left_on cyc=%0d got=%b want=%b", k, obs, exp_v);
            end
        end
        for (int k = 1; k <= 10; k++) exp_q.push_back(pack(k < 7, 1'b0, 1'b0, k == 7, 1'b0));
        raw_left = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick;
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL single_left_off cyc=%0d got=%b want=%b", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_glitch;
        for (int k = 1; k <= 12; k++) exp_q.push_back(5'b00000);
        raw_left = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick;
            if (k == 3) raw_left = 1'b0;
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL glitch cyc=%0d got=%b want=%b", k, obs, exp_v);
            end
        end
        checks++;
        if (dut.cnt_r[0] !== 3'd0) begin
            errors++;
            $display("FAIL glitch_cnt got=%0d want=0", dut.cnt_r[0]);
        end
    endtask

    task automatic test_first_come;
        for (int k = 1; k <= 42; k++)
            exp_q.push_back(pack(k >= 7 && k <= 26, k >= 28 && k <= 38, 1'b0,
                                 k == 7 || k == 27 || k == 28 || k == 39,
                                 k >= 16 && k <= 25));
        raw_left = 1'b1;
        for (int k = 1; k <= 42; k++) begin
            tick;
            if (k == 10) raw_right = 1'b1;
            if (k == 20) raw_left = 1'b0;
            if (k == 32) raw_right = 1'b0;
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL first_come cyc=%0d got=%b want=%b", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_both_turns;
        for (int k = 1; k <= 20; k++)
            exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 1'b0, k >= 6 && k <= 15));
        raw_left  = 1'b1;
        raw_right = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick;
            if (k == 10) begin
                raw_left  = 1'b0;
                raw_right = 1'b0;
            end
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL both_turns cyc=%0d got=%b want=%b", k, obs, exp_v);
            end
        end
    endtask

`ifdef VLC_COND_LATCH_EN
    task automatic test_hazard;
        for (int k = 1; k <= 74; k++)
            exp_q.push_back(pack((k >= 7 && k <= 16) || (k >= 48 && k <= 70), 1'b0,
                                 k >= 17 && k <= 46,
                                 k == 7 || k == 17 || k == 47 || k == 48 || k == 71, 1'b0));
        raw_left = 1'b1;
        for (int k = 1; k <= 74; k++) begin
            tick;
            if (k == 10) raw_emerg = 1'b1;
            if (k == 30) raw_emerg = 1'b0;
            if (k == 40) raw_emerg = 1'b1;
            if (k == 60) raw_emerg = 1'b0;
            if (k == 64) raw_left = 1'b0;
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL hazard_latch cyc=%0d got=%b want=%b", k, obs, exp_v);
            end
        end
    endtask
`else
    task automatic test_hazard;
        for (int k = 1; k <= 40; k++)
            exp_q.push_back(pack((k >= 7 && k <= 16) || (k >= 28 && k <= 36), 1'b0,
                                 k >= 17 && k <= 26,
                                 k == 7 || k == 17 || k == 27 || k == 28 || k == 37, 1'b0));
        raw_left = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick;
            if (k == 10) raw_emerg = 1'b1;
            if (k == 20) raw_emerg = 1'b0;
            if (k == 30) raw_left = 1'b0;
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL hazard_level cyc=%0d got=%b want=%b", k, obs, exp_v);
            end
        end
    endtask
`endif

    task automatic test_reset_mid;
        for (int k = 1; k <= 10; k++) exp_q.push_back(pack(1'b0, 1'b0, k >= 7, k == 7, 1'b0));
        raw_emerg = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick;
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL reset_mid_enter cyc=%0d got=%b want=%b", k, obs, exp_v);
            end
        end
        rst = 1'b1;
        #2;
        checks++;
        if (obs !== 5'b00000) begin
            errors++;
            $display("FAIL reset_async got=%b want=00000", obs);
        end
        tick;
        tick;
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) exp_q.push_back(pack(1'b0, 1'b0, k >= 7, k == 7, 1'b0));
        for (int k = 1; k <= 10; k++) begin
            tick;
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL reset_mid_return cyc=%0d got=%b want=%b", k, obs, exp_v);
            end
        end
`ifdef VLC_COND_LATCH_EN
        for (int k = 1; k <= 10; k++) exp_q.push_back(pack(1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
`else
        for (int k = 1; k <= 10; k++) exp_q.push_back(pack(1'b0, 1'b0, k < 7, k == 7, 1'b0));
`endif
        raw_emerg = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick;
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL reset_mid_release cyc=%0d got=%b want=%b", k, obs, exp_v);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        raw_left  = 1'b0;
        raw_right = 1'b0;
        raw_emerg = 1'b0;
        test_reset;
        test_single_left;
        test_glitch;
        test_first_come;
        test_both_turns;
        test_hazard;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
